// File: rtl/amber_core.sv
// amber_core: single-cycle 24-bit core with a four-entry capability register file.
// Optional macro AMBER_CHERI_CHECK_EN enables tag and bounds checking on capability ops.

package amber_pkg;
  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_MOVSI  = 8'h01;
  localparam logic [7:0] OPC_CINC   = 8'h40;
  localparam logic [7:0] OPC_CSETBI = 8'h41;
  localparam logic [7:0] OPC_CANDP  = 8'h42;
  localparam logic [7:0] OPC_CGETP  = 8'h43;
  localparam logic [7:0] OPC_CCLRT  = 8'h44;
  localparam logic [7:0] OPC_CGETT  = 8'h45;
  localparam logic [7:0] OPC_HLT    = 8'hFF;

  localparam int CR_PERM_R_BIT  = 0;
  localparam int CR_PERM_W_BIT  = 1;
  localparam int CR_PERM_X_BIT  = 2;
  localparam int CR_PERM_SB_BIT = 5;

  typedef struct packed {
    logic [47:0] base;
    logic [47:0] len;
    logic [47:0] cur;
    logic [23:0] perms;
    logic [23:0] attr;
    logic        tag;
  } cap_t;
endpackage

module amber_imem #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          r_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [23:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [23:0]   rdata
);
  logic [23:0] r_mem [0:DEPTH-1];

  // NOTE: storage arrays carry no reset; their contents are owned by whoever loads them.
  always_ff @(posedge r_clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule

module amber_reggp (
  input  logic        r_clk,
  input  logic [3:0]  raddr,
  output logic [23:0] rdata,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [23:0] wdata
);
  logic [23:0] r_gp [0:15];

  always_ff @(posedge r_clk) begin
    if (we) r_gp[waddr] <= wdata;
  end

  assign rdata = r_gp[raddr];
endmodule

module amber_regcr
  import amber_pkg::*;
(
  input  logic       r_clk,
  input  logic [1:0] ra_addr,
  output cap_t       ra_cap,
  input  logic [1:0] rb_addr,
  output cap_t       rb_cap,
  input  logic       we,
  input  logic [1:0] waddr,
  input  cap_t       wcap
);
  logic [47:0] r_base  [0:3];
  logic [47:0] r_len   [0:3];
  logic [47:0] r_cur   [0:3];
  logic [23:0] r_perms [0:3];
  logic [23:0] r_attr  [0:3];
  logic        r_tag   [0:3];

  // Whole-capability write: the core does read-modify-write, so untouched fields rewrite themselves.
  always_ff @(posedge r_clk) begin
    if (we) begin
      r_base[waddr]  <= wcap.base;
      r_len[waddr]   <= wcap.len;
      r_cur[waddr]   <= wcap.cur;
      r_perms[waddr] <= wcap.perms;
      r_attr[waddr]  <= wcap.attr;
      r_tag[waddr]   <= wcap.tag;
    end
  end

  assign ra_cap = '{base: r_base[ra_addr], len: r_len[ra_addr], cur: r_cur[ra_addr],
                    perms: r_perms[ra_addr], attr: r_attr[ra_addr], tag: r_tag[ra_addr]};
  assign rb_cap = '{base: r_base[rb_addr], len: r_len[rb_addr], cur: r_cur[rb_addr],
                    perms: r_perms[rb_addr], attr: r_attr[rb_addr], tag: r_tag[rb_addr]};
endmodule

module amber_core
  import amber_pkg::*;
#(
  parameter int IMEM_DEPTH = 4096
) (
  input logic iw_clk,
  input logic iw_rst
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [23:0] r_pc;
  logic        r_halted;
  logic [23:0] inst;
  logic [7:0]  opc;
  logic [AW-1:0] imem_addr;
  logic        exec;

  logic [23:0] gp_rd;
  logic        gp_we;
  logic [23:0] gp_wdata;
  cap_t        cr_a;
  cap_t        cr_b;
  logic        cr_we;
  cap_t        cr_wcap;
  logic        unused_cr_b;

  assign imem_addr = AW'(r_pc % 24'(IMEM_DEPTH));
  assign opc       = inst[23:16];
  assign exec      = !r_halted && !iw_rst;

  amber_imem #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
    .r_clk (iw_clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (imem_addr),
    .rdata (inst)
  );

  amber_reggp u_reggp (
    .r_clk (iw_clk),
    .raddr (inst[13:10]),
    .rdata (gp_rd),
    .we    (gp_we),
    .waddr (inst[15:12]),
    .wdata (gp_wdata)
  );

  // Port A always addresses the target capability, port B the source.
  amber_regcr u_regcr (
    .r_clk   (iw_clk),
    .ra_addr (inst[15:14]),
    .ra_cap  (cr_a),
    .rb_addr (inst[11:10]),
    .rb_cap  (cr_b),
    .we      (cr_we),
    .waddr   (inst[15:14]),
    .wcap    (cr_wcap)
  );

  assign unused_cr_b = ^{cr_b.base, cr_b.len, cr_b.attr};

`ifdef AMBER_CHERI_CHECK_EN
  logic [48:0] src_end;
  logic [48:0] new_end;
  logic        in_range;

  assign src_end  = {1'b0, cr_b.base} + {1'b0, cr_b.len};
  assign new_end  = {1'b0, cr_b.cur} + {39'd0, inst[9:0]};
  assign in_range = (cr_b.cur >= cr_b.base) && (new_end <= src_end);
`endif

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    gp_we    = 1'b0;
    gp_wdata = '0;
    cr_we    = 1'b0;
    cr_wcap  = cr_a;
    case (opc)
      OPC_MOVSI: begin
        gp_we    = 1'b1;
        gp_wdata = {{12{inst[11]}}, inst[11:0]};
      end
      OPC_CINC: begin
        cr_we       = 1'b1;
        cr_wcap.cur = cr_a.cur + {{24{gp_rd[23]}}, gp_rd};
      end
      OPC_CSETBI: begin
        cr_we        = 1'b1;
        cr_wcap.base = cr_b.cur;
        cr_wcap.len  = {38'd0, inst[9:0]};
`ifdef AMBER_CHERI_CHECK_EN
        if (!in_range) cr_wcap.tag = 1'b0;
`endif
      end
      OPC_CANDP: begin
        cr_we         = 1'b1;
        cr_wcap.perms = cr_a.perms & gp_rd;
      end
      OPC_CGETP: begin
        gp_we    = 1'b1;
        gp_wdata = cr_b.perms;
      end
      OPC_CCLRT: begin
        cr_we       = 1'b1;
        cr_wcap.tag = 1'b0;
      end
      OPC_CGETT: begin
        gp_we    = 1'b1;
        gp_wdata = {23'd0, cr_b.tag};
      end
      default: ;
    endcase
`ifdef AMBER_CHERI_CHECK_EN
    if ((opc == OPC_CINC || opc == OPC_CANDP) && !cr_a.tag) cr_we = 1'b0;
    if (opc == OPC_CSETBI && !(cr_a.tag && cr_b.tag)) cr_we = 1'b0;
`endif
    if (!exec) begin
      gp_we = 1'b0;
      cr_we = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_pc     <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (opc == OPC_HLT) r_halted <= 1'b1;
      else                r_pc     <= r_pc + 24'd1;
    end
  end
endmodule

// File: tb/tb_amber_core.sv
// Directed ISA bench for amber_core: preloads imem/registers hierarchically and checks state per step.

module tb_amber_core;
  logic iw_clk;
  logic iw_rst;

  int n_vec = 0;
  int n_err = 0;

  amber_core #(.IMEM_DEPTH(4096)) dut (
    .iw_clk (iw_clk),
    .iw_rst (iw_rst)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iw_clk);
    #1;
  endtask

  logic [23:0] prog [0:13];
  logic [47:0] exp_cur;

  initial begin
    prog[0]  = 24'h011005; // MOVsi DR1,#5
    prog[1]  = 24'h400400; // CINC  CR0,DR1
    prog[2]  = 24'h410014; // CSETBi CR0,CR0,#20
    prog[3]  = 24'h012001; // MOVsi DR2,#1
    prog[4]  = 24'h000000; // NOP
    prog[5]  = 24'h420800; // CANDP CR0,DR2
    prog[6]  = 24'h433000; // CGETP DR3,CR0
    prog[7]  = 24'h440000; // CCLRT CR0
    prog[8]  = 24'h454000; // CGETT DR4,CR0
    prog[9]  = 24'h015FFF; // MOVsi DR5,#0xFFF
    prog[10] = 24'h405400; // CINC  CR1,DR5
    prog[11] = 24'h7E1234; // undefined -> NOP
    prog[12] = 24'hFF0000; // HLT
    prog[13] = 24'h01F123; // must never run

    iw_rst = 1'b0;
    #2 iw_rst = 1'b1;
    for (int i = 0; i < 4096; i++) dut.u_imem.r_mem[i] <= 24'h000000;
    for (int i = 0; i < 16; i++) dut.u_reggp.r_gp[i] <= 24'h000000;
    for (int i = 0; i < 4; i++) begin
      dut.u_regcr.r_base[i]  <= '0;
      dut.u_regcr.r_len[i]   <= '0;
      dut.u_regcr.r_cur[i]   <= '0;
      dut.u_regcr.r_perms[i] <= '0;
      dut.u_regcr.r_attr[i]  <= '0;
      dut.u_regcr.r_tag[i]   <= 1'b0;
    end
    #0;
    for (int i = 0; i < 14; i++) dut.u_imem.r_mem[i] <= prog[i];
    dut.u_reggp.r_gp[4]     <= 24'h555555;
    dut.u_reggp.r_gp[15]    <= 24'hABCDEF;
    dut.u_regcr.r_base[0]   <= 48'd100;
    dut.u_regcr.r_len[0]    <= 48'd50;
    dut.u_regcr.r_cur[0]    <= 48'd100;
    dut.u_regcr.r_perms[0]  <= 24'h000023;
    dut.u_regcr.r_tag[0]    <= 1'b1;
    dut.u_regcr.r_tag[1]    <= 1'b1;
    #1;
    check("rst_pc", dut.r_pc, 48'd0);
    check("rst_halted", dut.r_halted, 48'd0);

    @(negedge iw_clk) iw_rst = 1'b0;
    check("preload_held", dut.u_regcr.r_cur[0], 48'd100);

    step(); check("movsi_dr1", dut.u_reggp.r_gp[1], 48'd5);
            check("pc_1", dut.r_pc, 48'd1);
    step(); check("cinc_cur", dut.u_regcr.r_cur[0], 48'd105);
    step(); check("csetb_base", dut.u_regcr.r_base[0], 48'd105);
            check("csetb_len", dut.u_regcr.r_len[0], 48'd20);
            check("csetb_cur", dut.u_regcr.r_cur[0], 48'd105);
            check("csetb_tag", dut.u_regcr.r_tag[0], 48'd1);
    step(); check("movsi_dr2", dut.u_reggp.r_gp[2], 48'd1);
    step(); check("nop_pc", dut.r_pc, 48'd5);
    step(); check("candp_perms", dut.u_regcr.r_perms[0], 48'd1);
    step(); check("cgetp_dr3", dut.u_reggp.r_gp[3], 48'd1);
    step(); check("cclrt_tag", dut.u_regcr.r_tag[0], 48'd0);
    step(); check("cgett_dr4", dut.u_reggp.r_gp[4], 48'd0);
    step(); check("movsi_neg", dut.u_reggp.r_gp[5], 48'hFFFFFF);
    step(); check("cinc_wrap", dut.u_regcr.r_cur[1], 48'hFFFFFFFFFFFF);
    step(); check("undef_pc", dut.r_pc, 48'd12);
            check("undef_dr1", dut.u_reggp.r_gp[1], 48'd5);
    step(); check("hlt_flag", dut.r_halted, 48'd1);
            check("hlt_pc", dut.r_pc, 48'd12);

    for (int i = 0; i < 80; i++) begin
      step();
      check("hold_pc", dut.r_pc, 48'd12);
    end
    check("hold_dr15", dut.u_reggp.r_gp[15], 48'hABCDEF);
    check("hold_perms", dut.u_regcr.r_perms[0], 48'd1);

    @(negedge iw_clk) iw_rst = 1'b1;
    #1;
    check("mid_rst_pc", dut.r_pc, 48'd0);
    check("mid_rst_halted", dut.r_halted, 48'd0);
    check("keep_dr3", dut.u_reggp.r_gp[3], 48'd1);
    check("keep_cr1", dut.u_regcr.r_cur[1], 48'hFFFFFFFFFFFF);
    check("keep_cr0_base", dut.u_regcr.r_base[0], 48'd105);
    @(negedge iw_clk) iw_rst = 1'b0;
    check("rst_held_pc", dut.r_pc, 48'd0);

    step(); check("restart_pc", dut.r_pc, 48'd1);
            check("restart_dr1", dut.u_reggp.r_gp[1], 48'd5);
`ifdef AMBER_CHERI_CHECK_EN
    exp_cur = 48'd105;
`else
    exp_cur = 48'd110;
`endif
    step(); check("rerun_cinc", dut.u_regcr.r_cur[0], exp_cur);
            check("rerun_pc", dut.r_pc, 48'd2);

    @(negedge iw_clk) iw_rst = 1'b1;
    #1;
    check("abort_pc", dut.r_pc, 48'd0);
    @(negedge iw_clk) iw_rst = 1'b0;
    step(); check("abort_restart_pc", dut.r_pc, 48'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/amber_core.md
Name: amber_core

Overview:
- Minimal non-pipelined 24-bit processor core with a small CHERI-style capability register file.
- Each instruction executes in one clock from an internal asynchronous-read instruction memory, with no external bus.
- Intended as the top-level core for directed ISA benches, which preload memory and registers through hierarchical references.
- Required internal instance names: u_imem (array r_mem), u_reggp (array r_gp), u_regcr (arrays r_base, r_len, r_cur, r_perms, r_attr, r_tag).

Parameters:
- IMEM_DEPTH, 4096, instruction words in u_imem; the PC indexes modulo depth.

Ports:
- iw_clk  input  1  sole clock, all state updates on rising edge.
- iw_rst  input  1  asynchronous, active-high reset.

Behaviour:
- State:
  - PC, 24 bits.
  - halted flag.
  - u_reggp.r_gp[0:15], each 24 bits (DR0-DR15, all writable).
  - u_regcr[0:3]: r_base, r_len, r_cur 48 bits each; r_perms, r_attr 24 bits each; r_tag 1 bit.
  - u_imem.r_mem[0:IMEM_DEPTH-1], each 24 bits.
- Reset: iw_rst high forces PC=0 and halted=0 immediately.
  - DR and CR files, and imem, are NOT reset, so values preloaded after reset persist.
  - Reset asserted mid-program aborts at once; execution restarts at word 0 on the first rising edge after release.
- Instruction format: inst = r_mem[PC], read combinationally. opc = inst[23:16].
- Opcodes, from opcodes.vh: OPC_NOP=8'h00, OPC_MOVsi=8'h01, OPC_CINC=8'h40, OPC_CSETBi=8'h41, OPC_CANDP=8'h42, OPC_CGETP=8'h43, OPC_CCLRT=8'h44, OPC_CGETT=8'h45, OPC_HLT=8'hFF.
- Permission bits, from cr.vh: CR_PERM_R_BIT=0, CR_PERM_W_BIT=1, CR_PERM_X_BIT=2, CR_PERM_SB_BIT=5.
- Execution: each rising edge with halted=0 executes one instruction, commits all writes, and sets PC=PC+1 (24-bit wrap). Results are visible to the very next instruction, with no hazards.
- Instruction semantics:
  - MOVsi {opc, DRt[15:12], imm12[11:0]}: DRt := sign-extend imm12 to 24 bits.
  - CINC {opc, CRt[15:14], DRs[13:10], 0}: CRt.cur := CRt.cur + sign-extend48(DRs), 48-bit wrap.
  - CSETBi {opc, CRt[15:14], imm14[13:0]}: CRs = imm14[11:10]. CRt.base := CRs.cur; CRt.len := zero-extend(imm14[9:0]). CRt.cur, perms, attr and tag are unchanged.
  - CANDP {opc, CRt[15:14], DRs[13:10], 0}: CRt.perms := CRt.perms & DRs.
  - CGETP {opc, DRt[15:12], CRs[11:10], 0}: DRt := CRs.perms.
  - CCLRT {opc, CRt[15:14], 0}: CRt.tag := 0.
  - CGETT {opc, DRt[15:12], CRs[11:10], 0}: DRt := {23'b0, CRs.tag}.
  - HLT: set halted=1. PC does not advance. No further state changes until reset.
  - Any undefined opcode executes as NOP.
- No bounds, permission or tag checks are applied to these operations, except when the optional feature below is enabled.

Optional Feature:
- Macro AMBER_CHERI_CHECK_EN.
- Defined:
  - CINC, CSETBi and CANDP applied to a CRt (or CSETBi source CRs) with tag=0 write nothing.
  - CSETBi whose new range [CRs.cur, CRs.cur+len) is not within the source [base, base+len) commits base and len but clears CRt.tag.
- Undefined: no checks; semantics exactly as listed above.

Test Plan:
- CR0 preload: base=100, len=50, cur=100, perms=R|W|SB (0x23), tag=1. Program: MOVsi #5,DR1; CINC DR1,CR0 -> CR0.cur=105.
- Continue: CSETBi CR0, imm14=20, CRt=CR0 -> CR0.base=105, CR0.len=20, cur stays 105.
- Continue: MOVsi #1,DR2; CANDP DR2,CR0; CGETP CR0,DR3 -> CR0.perms=1, DR3=1 (NOPs in between are harmless).
- Continue: CCLRT CR0; CGETT CR0,DR4; HLT -> CR0.tag=0, DR4=0. PC frozen at the HLT address through 80 cycles.
- MOVsi #0xFFF,DR5 -> DR5=0xFFFFFF. Then CINC DR5,CR1 with CR1.cur=0 -> CR1.cur=0xFFFFFFFFFFFF.
- Assert iw_rst for one cycle mid-program -> PC=0 and halted=0 at once; DR and CR contents retained.
